// File: rtl/apb_cmd_master.sv
// Command-to-APB4 bridge: runs one SETUP/ACCESS transfer per accepted command and
// returns read data / error / timeout on a valid-ready response channel.
module apb_cmd_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                pclk,
    input  logic                preset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_slverr,
    output logic                rsp_timeout,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready,
    input  logic                pslverr
);
    localparam int              CW    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit              TO_EN = (TIMEOUT != 0);
    localparam logic [CW-1:0]   LIMIT = CW'(TO_EN ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0]   CMAX  = '1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt;
    logic          accept, done, abort;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign done      = (state == ACCESS) && pready;
    // pready in the limit cycle wins, so abort requires !pready
    assign abort     = TO_EN && (state == ACCESS) && !pready && (wait_cnt == LIMIT);

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (done || abort) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    paddr   <= cmd_addr;
                    pwrite  <= cmd_write;
                    pwdata  <= cmd_write ? cmd_wdata : '0;
                    pstrb   <= cmd_write ? cmd_strb  : '0;
                    psel    <= 1'b1;
                    penable <= 1'b0;
                end
                SETUP: begin
                    penable  <= 1'b1;
                    wait_cnt <= '0;
                end
                ACCESS: begin
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_slverr  <= pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                    end else begin
                        if (wait_cnt != CMAX) wait_cnt <= wait_cnt + CW'(1);
                        if (abort) begin
                            psel        <= 1'b0;
                            penable     <= 1'b0;
                            rsp_rdata   <= '0;
                            rsp_slverr  <= 1'b1;
                            rsp_timeout <= 1'b1;
                            rsp_valid   <= 1'b1;
                        end
                    end
                end
                RESP: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: stimulus pushes expected responses into a queue,
// a negedge monitor pops and compares on every response handshake.
module tb_apb_cmd_master;
    logic        pclk = 1'b0, preset_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_slverr, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [31:0] paddr, pwdata, prdata;
    logic [3:0]  pstrb;

    int          slv_wait = 0;
    logic        slv_err = 1'b0;
    logic [31:0] slv_rdata = '0;
    int          acc_cnt = 0;

    int total = 0, bad = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        slverr, tmo;
        int          pen;
        logic [31:0] addr, wdata;
        logic [3:0]  strb;
        logic        wr;
    } exp_t;
    exp_t q[$];

    apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
        .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    // slave: pready after slv_wait stalled ACCESS cycles; slv_wait<0 never ready
    assign pready  = psel && penable && (slv_wait >= 0) && (acc_cnt == slv_wait);
    assign prdata  = slv_rdata;
    assign pslverr = slv_err;

    always @(posedge pclk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else if (!penable)              acc_cnt <= 0;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // monitor: APB phase tracking plus response scoreboard
    initial begin
        logic        prev_setup = 0, pen_prev = 0, pv = 0, pr = 0, stable = 1;
        logic [31:0] cap_addr = '0, cap_wd = '0, h_rd = '0;
        logic [3:0]  cap_st = '0;
        logic        cap_wr = 0, h_se = 0, h_to = 0;
        int          pen_cnt = 0;
        exp_t        e;
        forever begin
            @(negedge pclk);
            if (!preset_n) begin
                prev_setup = 0; pen_prev = 0; pv = 0; pr = 0;
            end else begin
                if (psel && !penable) begin
                    cap_addr = paddr; cap_wr = pwrite; cap_wd = pwdata; cap_st = pstrb;
                    pen_cnt = 0; stable = 1;
                end
                if (psel && penable) begin
                    if (!pen_prev) chk("setup_before_enable", {63'd0, prev_setup}, 64'd1);
                    pen_cnt++;
                    if (paddr !== cap_addr || pwrite !== cap_wr || pwdata !== cap_wd || pstrb !== cap_st)
                        stable = 0;
                end
                prev_setup = psel && !penable;
                pen_prev   = psel && penable;
                if (rsp_valid && pv && !pr)
                    chk("rsp_hold", {rsp_rdata, 30'd0, rsp_slverr, rsp_timeout},
                        {h_rd, 30'd0, h_se, h_to});
                if (rsp_valid && rsp_ready) begin
                    if (q.size() == 0) chk("unexpected_rsp", 64'd1, 64'd0);
                    else begin
                        e = q.pop_front();
                        chk("rsp_rdata",   {32'd0, rsp_rdata},   {32'd0, e.rdata});
                        chk("rsp_slverr",  {63'd0, rsp_slverr},  {63'd0, e.slverr});
                        chk("rsp_timeout", {63'd0, rsp_timeout}, {63'd0, e.tmo});
                        chk("penable_cycles", 64'(pen_cnt), 64'(e.pen));
                        chk("apb_addr",  {32'd0, cap_addr}, {32'd0, e.addr});
                        chk("apb_wdata", {32'd0, cap_wd},   {32'd0, e.wdata});
                        chk("apb_strb_dir", {59'd0, cap_st, cap_wr}, {59'd0, e.strb, e.wr});
                        chk("apb_stable", {63'd0, stable}, 64'd1);
                    end
                end
                pv = rsp_valid; pr = rsp_ready;
                h_rd = rsp_rdata; h_se = rsp_slverr; h_to = rsp_timeout;
            end
        end
    end

    task automatic step();
        @(posedge pclk); #1;
    endtask

    task automatic push(input logic [31:0] rd, input logic se, input logic to, input int pen,
                        input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                        input logic wr);
        exp_t e;
        e.rdata = rd; e.slverr = se; e.tmo = to; e.pen = pen;
        e.addr = a; e.wdata = wd; e.strb = st; e.wr = wr;
        q.push_back(e);
    endtask

    // drive a command and hold it until accepted; waits = cycles cmd_ready was low
    task automatic do_cmd(input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] st, output int waits);
        bit ok = 0;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = wd; cmd_strb = st;
        waits = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge pclk);
            if (cmd_ready) ok = 1;
            else waits++;
            @(posedge pclk); #1;
        end
        cmd_valid = 0;
        if (!ok) chk("cmd_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge pclk);
            if (q.size() == 0) ok = 1;
        end
        if (!ok) chk("drain_timeout", 64'(q.size()), 64'd0);
        step();
    endtask

    initial begin
        int w;
        bit seen;
        #12;
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rst_apb", {30'd0, paddr, psel, penable}, 64'd0);
        chk("rst_rsp", {29'd0, rsp_rdata, rsp_valid, rsp_slverr, rsp_timeout}, 64'd0);
        step(); preset_n = 1; step();

        // write, zero wait states; prdata nonzero must not leak into rsp_rdata
        slv_wait = 0; slv_err = 0; slv_rdata = 32'h1111_2222;
        push(32'h0, 0, 0, 1, 32'h4, 32'hA5A5_1234, 4'hF, 1);
        do_cmd(1, 32'h4, 32'hA5A5_1234, 4'hF, w);
        drain();

        // read with 3 wait states; wdata/strb must be zeroed for reads
        slv_wait = 3; slv_rdata = 32'hDEAD_BEEF;
        push(32'hDEAD_BEEF, 0, 0, 4, 32'h10, 32'h0, 4'h0, 0);
        do_cmd(0, 32'h10, 32'hFFFF_FFFF, 4'hF, w);
        drain();

        // write with slave error, then a normal read back-to-back
        slv_wait = 0; slv_err = 1;
        push(32'h0, 1, 0, 1, 32'h20, 32'h0BAD_F00D, 4'h3, 1);
        do_cmd(1, 32'h20, 32'h0BAD_F00D, 4'h3, w);
        drain();
        slv_err = 0; slv_rdata = 32'h0000_5A5A;
        push(32'h0000_5A5A, 0, 0, 1, 32'h24, 32'h0, 4'h0, 0);
        do_cmd(0, 32'h24, 32'h0, 4'h0, w);
        drain();

        // slave never ready: abort after 16 ACCESS cycles
        slv_wait = -1; slv_rdata = 32'hCAFE_0001;
        push(32'h0, 1, 1, 16, 32'h30, 32'h0, 4'h0, 0);
        do_cmd(0, 32'h30, 32'h0, 4'h0, w);
        drain();

        // pready in the 16th ACCESS cycle wins over the timeout
        slv_wait = 15;
        push(32'hCAFE_0001, 0, 0, 16, 32'h34, 32'h0, 4'h0, 0);
        do_cmd(0, 32'h34, 32'h0, 4'h0, w);
        drain();

        // response backpressure: held response, pending command refused
        slv_wait = 0; rsp_ready = 0;
        push(32'h0, 0, 0, 1, 32'h40, 32'h1234_5678, 4'h8, 1);
        do_cmd(1, 32'h40, 32'h1234_5678, 4'h8, w);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge pclk);
            if (rsp_valid) seen = 1;
        end
        chk("rsp_valid_seen", {63'd0, seen}, 64'd1);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h99;
        repeat (5) begin
            @(negedge pclk);
            chk("cmd_ready_in_resp", {63'd0, cmd_ready}, 64'd0);
        end
        step(); rsp_ready = 1;
        slv_rdata = 32'h7777_0000;
        push(32'h7777_0000, 0, 0, 1, 32'h44, 32'h0, 4'h0, 0);
        do_cmd(0, 32'h44, 32'h0, 4'h0, w);
        chk("accept_after_rsp", 64'(w), 64'd1);
        drain();

        // reset during ACCESS: outputs drop at once, no response follows
        slv_wait = -1;
        do_cmd(0, 32'h50, 32'h0, 4'h0, w);
        step(); step();
        #2 preset_n = 0;
        #1;
        chk("rst_mid_apb", {61'd0, psel, penable, rsp_valid}, 64'd0);
        chk("rst_mid_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        step(); step(); preset_n = 1;
        slv_wait = 0;
        @(negedge pclk);
        chk("post_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        repeat (20) @(negedge pclk);
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
Command-to-APB bridge that generates APB4 master transfers on the per-UART APB port of dut_top, i.e. the traffic the APB protocol checkers observe. It accepts one read/write command over a valid/ready interface and runs a single SETUP/ACCESS transfer. It returns read data, the error flag and a timeout flag over a valid/ready response interface. A wait-state timeout guarantees that a hung slave cannot stall the bench.

Parameters:
ADDR_W, 32, width of paddr/cmd_addr
DATA_W, 32, width of pwdata/prdata (multiple of 8)
TIMEOUT, 16, max ACCESS cycles with pready=0 before abort; 0 disables the timeout

Ports:
pclk  in  1  APB clock, all logic rising-edge
preset_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  transfer address
cmd_wdata  in  DATA_W  write data
cmd_strb  in  DATA_W/8  write byte strobes
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
rsp_rdata  out  DATA_W  read data (0 for writes/timeouts)
rsp_slverr  out  1  pslverr captured, or timeout
rsp_timeout  out  1  transfer aborted by timeout
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
pstrb  out  DATA_W/8  APB strobes
prdata  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB error

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs 0 except cmd_ready=1. Wait counter=0.
- All APB and rsp_* outputs are registered. cmd_ready = (state==IDLE), combinational from state.
- IDLE: on accept, the next edge loads paddr=cmd_addr and pwrite=cmd_write. For a write it loads pwdata=cmd_wdata and pstrb=cmd_strb; for a read it loads pwdata=0 and pstrb=0. It also sets psel=1, penable=0 and moves to SETUP.
- SETUP (1 cycle): next edge sets penable=1, clears the counter, moves to ACCESS.
- ACCESS, pready=1:
  - Next edge sets psel=0 and penable=0.
  - rsp_rdata = read ? prdata : 0; rsp_slverr = pslverr; rsp_timeout = 0; rsp_valid = 1.
  - Moves to RESP.
- ACCESS, pready=0: the counter increments. If TIMEOUT!=0 and the counter reaches TIMEOUT-1 on this cycle, the next edge aborts:
  - psel=0, penable=0.
  - rsp_rdata=0, rsp_slverr=1, rsp_timeout=1, rsp_valid=1.
  - Moves to RESP.
  - Result: the abort happens after exactly TIMEOUT ACCESS cycles without pready.
- A pready arriving in the same cycle as the counter limit wins: normal completion, no timeout.
- RESP: rsp_* are held stable while rsp_valid=1 and rsp_ready=0. On rsp_ready the next edge clears rsp_valid and moves to IDLE.
- Minimum transfer: accept, SETUP, ACCESS, RESP. Back-to-back commands give at least 4 cycles between SETUP phases.
- paddr, pwrite, pwdata and pstrb are stable from SETUP through the last ACCESS cycle. After the transfer they keep their values; only psel/penable return to 0.
- pready, pslverr and prdata are ignored outside ACCESS.
- cmd_* inputs are ignored outside IDLE.
- Counter width is clog2(TIMEOUT+1), minimum 1; it saturates and never wraps.
- Reset mid-transfer: the transfer is abandoned, psel/penable drop asynchronously, and no response is generated.

Test Plan:
- Write addr=0x0000_0004, wdata=0xA5A5_1234, strb=0xF, pready tied 1 -> psel 1 cycle before penable, penable high exactly 1 cycle, rsp_valid 1 cycle later with slverr=0, timeout=0, rdata=0.
- Read addr=0x0000_0010, slave holds pready=0 for 3 ACCESS cycles then returns prdata=0xDEAD_BEEF -> penable high 4 cycles, paddr stable throughout, pstrb=0, rsp_rdata=0xDEAD_BEEF.
- Write with pready=1, pslverr=1 -> rsp_slverr=1, rsp_timeout=0; next command is accepted normally.
- TIMEOUT=16, pready held 0 -> abort after 16 ACCESS cycles, rsp_slverr=1, rsp_timeout=1, rsp_rdata=0. Repeat with pready=1 in the 16th cycle -> normal completion.
- rsp_ready held 0 for 5 cycles after completion -> rsp_* stable, cmd_ready=0 and a pending cmd_valid is not accepted until 1 cycle after rsp_ready.
- Assert preset_n=0 during ACCESS -> psel/penable/rsp_valid=0 immediately, cmd_ready=1 after release, no response emitted.
